// File: rtl/rf_wport_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter_if
// Description : WB / MU request, register-file write and PC-load signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wport_arbiter_if;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mu_req;
    logic [3:0]  mu_rd;
    logic [31:0] mu_data;
    logic        mu_gnt;
    logic        bl;
    logic        rf_ld;
    logic [3:0]  rf_sel;
    logic [31:0] rf_ds;
    logic        pc_ld;
    logic [31:0] pc_data;
    logic        overflow;

    modport master (
        output wb_valid, wb_rd, wb_data, mu_req, mu_rd, mu_data, bl,
        input  wb_stall, mu_gnt, rf_ld, rf_sel, rf_ds, pc_ld, pc_data, overflow
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, mu_req, mu_rd, mu_data, bl,
        output wb_stall, mu_gnt, rf_ld, rf_sel, rf_ds, pc_ld, pc_data, overflow
    );
endinterface
`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter
// Description : Register-file write-port arbiter between WB and the MU, with an
//               in-order WB holding FIFO, R14/BL deferral and R15 redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int HB_DEPTH = 2
) (
    input  wire logic          clock,
    input  wire logic          reset,
    rf_wport_arbiter_if.slave  bus
);
    localparam int c_CNT_W  = $clog2(HB_DEPTH + 1);
    localparam int c_PTR_W  = (HB_DEPTH > 1) ? $clog2(HB_DEPTH) : 1;
    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [c_CNT_W-1:0]  c_DEPTH    = c_CNT_W'(HB_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_STALL_TH = c_CNT_W'(HB_DEPTH - 1);
    localparam logic [c_PTR_W-1:0]  c_LAST_PTR = c_PTR_W'(HB_DEPTH - 1);
    localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);
    localparam logic [3:0]          c_R14      = 4'd14;
    localparam logic [3:0]          c_R15      = 4'd15;

    logic [3:0]          r_hb_rd   [HB_DEPTH];
    logic [31:0]         r_hb_data [HB_DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_WAIT_W-1:0] r_wait;

    logic                w_run;
    logic                w_from_fifo;
    logic                w_head_valid;
    logic [3:0]          w_head_rd;
    logic [31:0]         w_head_data;
    logic                w_wb_blk;
    logic                w_mu_blk;
    logic                w_starve;
    logic                w_issue_mu;
    logic                w_issue_wb;
    logic                w_issue;
    logic [3:0]          w_iss_rd;
    logic [31:0]         w_iss_data;
    logic                w_pop;
    logic                w_push;
    logic                w_push_ok;
    logic                w_drop;
    logic [c_CNT_W-1:0]  w_count_nxt;

    // reset is active-low; while asserted nothing is accepted or issued
    assign w_run        = reset;
    assign w_from_fifo  = (r_count != '0);
    assign w_head_valid = w_from_fifo | bus.wb_valid;
    assign w_head_rd    = w_from_fifo ? r_hb_rd[r_rd_ptr]   : bus.wb_rd;
    assign w_head_data  = w_from_fifo ? r_hb_data[r_rd_ptr] : bus.wb_data;

    assign w_wb_blk = bus.bl && (w_head_rd == c_R14);
    assign w_mu_blk = bus.bl && (bus.mu_rd == c_R14);
    assign w_starve = bus.mu_req && (r_wait == c_MAX_WAIT);

    always_comb begin
        w_issue_mu = 1'b0;
        w_issue_wb = 1'b0;
        if (w_run) begin
            if (w_starve && !w_mu_blk) begin
                w_issue_mu = 1'b1;
            end else if (w_head_valid && !w_wb_blk) begin
                w_issue_wb = 1'b1;
            end else if (bus.mu_req && !w_mu_blk) begin
                w_issue_mu = 1'b1;
            end
        end
    end

    assign w_issue    = w_issue_mu | w_issue_wb;
    assign w_iss_rd   = w_issue_mu ? bus.mu_rd   : w_head_rd;
    assign w_iss_data = w_issue_mu ? bus.mu_data : w_head_data;
    assign bus.mu_gnt = w_issue_mu;

    // A live WB result goes to the FIFO unless it was itself the issued head
    assign w_pop     = w_issue_wb && w_from_fifo;
    assign w_push    = w_run && bus.wb_valid && !(w_issue_wb && !w_from_fifo);
    assign w_push_ok = w_push && ((r_count != c_DEPTH) || w_pop);
    assign w_drop    = w_push && !w_push_ok;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_hb_rd[r_wr_ptr]   <= bus.wb_rd;
            r_hb_data[r_wr_ptr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_wait       <= '0;
            bus.rf_ld    <= 1'b0;
            bus.rf_sel   <= 4'd0;
            bus.rf_ds    <= 32'd0;
            bus.pc_ld    <= 1'b0;
            bus.pc_data  <= 32'd0;
            bus.wb_stall <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            r_count <= w_count_nxt;

            if (!bus.mu_req || w_issue_mu) begin
                r_wait <= '0;
            end else if (r_wait != c_MAX_WAIT) begin
                r_wait <= r_wait + 1'b1;
            end

            bus.rf_ld <= w_issue && (w_iss_rd != c_R15);
            bus.pc_ld <= w_issue && (w_iss_rd == c_R15);
            if (w_issue && (w_iss_rd != c_R15)) begin
                bus.rf_sel <= w_iss_rd;
                bus.rf_ds  <= w_iss_data;
            end
            if (w_issue && (w_iss_rd == c_R15)) begin
                bus.pc_data <= w_iss_data;
            end

            // one slot stays free for the result arriving as the stall rises
            bus.wb_stall <= (w_count_nxt >= c_STALL_TH);
            bus.overflow <= bus.overflow | w_drop;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wport_arbiter
// Description : Vector table with a queue of expected registered outputs,
//               plus hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wport_arbiter;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   miscompares;

    rf_wport_arbiter_if bus ();

    rf_wport_arbiter #(.MAX_WAIT(3), .HB_DEPTH(2)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [3:0]  wrd;
        logic [31:0] wd;
        logic        mreq;
        logic [3:0]  mrd;
        logic [31:0] md;
        logic        bl;
        logic        egnt;
        logic        eld;
        logic [3:0]  esel;
        logic [31:0] eds;
        logic        epc;
        logic        estall;
        logic        eovf;
    } vec_t;

    typedef struct {
        logic        eld;
        logic [3:0]  esel;
        logic [31:0] eds;
        logic        epc;
        logic        estall;
        logic        eovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic wv, input logic [3:0] wrd, input logic [31:0] wd,
        input logic mreq, input logic [3:0] mrd, input logic [31:0] md,
        input logic bl, input logic egnt, input logic eld, input logic [3:0] esel,
        input logic [31:0] eds, input logic epc, input logic estall, input logic eovf);
        vec_t v;
        v.wv = wv; v.wrd = wrd; v.wd = wd; v.mreq = mreq; v.mrd = mrd; v.md = md;
        v.bl = bl; v.egnt = egnt; v.eld = eld; v.esel = esel; v.eds = eds;
        v.epc = epc; v.estall = estall; v.eovf = eovf;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (vector %0d)", nm, act, exp, n_vec);
        end
    endtask

    task automatic drive(input logic wv, input logic [3:0] wrd, input logic [31:0] wd,
                         input logic mreq, input logic [3:0] mrd, input logic [31:0] md,
                         input logic bl);
        bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
        bus.mu_req = mreq; bus.mu_rd = mrd; bus.mu_data = md; bus.bl = bl;
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, " rf_ld"},    32'(bus.rf_ld),    32'd0);
        cmp({tag, " rf_sel"},   32'(bus.rf_sel),   32'd0);
        cmp({tag, " rf_ds"},    bus.rf_ds,         32'd0);
        cmp({tag, " pc_ld"},    32'(bus.pc_ld),    32'd0);
        cmp({tag, " pc_data"},  bus.pc_data,       32'd0);
        cmp({tag, " wb_stall"}, 32'(bus.wb_stall), 32'd0);
        cmp({tag, " overflow"}, 32'(bus.overflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        n_vec = 0;
        miscompares = 0;
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);

        // wv wrd wd   mreq mrd md   bl | gnt ld sel ds  pc stall ovf
        // WB only, then WB/MU collision
        vecs.push_back(mk(1, 3,  32'h30303030, 0, 0, 0, 0, 0, 1, 3,  32'h30303030, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0));
        vecs.push_back(mk(1, 2,  32'h22222222, 1, 5, 32'h55555555, 0, 0, 1, 2, 32'h22222222, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 5, 32'h55555555, 0, 1, 1, 5, 32'h55555555, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0));
        // R15 redirect
        vecs.push_back(mk(1, 15, 32'h00000100, 0, 0, 0, 0, 0, 0, 0,  32'h00000100, 1, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0));
        // starvation: MU wins on its 4th request cycle, WB rd4 parked then drained
        vecs.push_back(mk(1, 1,  32'h11,       1, 9, 32'h99999999, 0, 0, 1, 1, 32'h11, 0, 0, 0));
        vecs.push_back(mk(1, 2,  32'h12,       1, 9, 32'h99999999, 0, 0, 1, 2, 32'h12, 0, 0, 0));
        vecs.push_back(mk(1, 3,  32'h13,       1, 9, 32'h99999999, 0, 0, 1, 3, 32'h13, 0, 0, 0));
        vecs.push_back(mk(1, 4,  32'h14,       1, 9, 32'h99999999, 0, 1, 1, 9, 32'h99999999, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 0, 0, 1, 4,  32'h14,       0, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0));
        // BL block of R14 head; MU rd7 issues meanwhile
        vecs.push_back(mk(1, 14, 32'hE0E0E0E0, 1, 7, 32'h77777777, 1, 1, 1, 7, 32'h77777777, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 1, 0, 0, 0,  0,            0, 1, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 0, 0, 1, 14, 32'hE0E0E0E0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 0, 0, 0, 0,  0,            0, 0, 0));
        // MU R14 blocked by bl, issues when bl drops
        vecs.push_back(mk(0, 0,  0,            1, 14, 32'hAAAAAAAA, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 14, 32'hAAAAAAAA, 0, 1, 1, 14, 32'hAAAAAAAA, 0, 0, 0));
        // fill the FIFO behind a blocked R14 head until a result is dropped
        vecs.push_back(mk(1, 14, 32'hE1,       0, 0, 0, 1, 0, 0, 0,  0,            0, 1, 0));
        vecs.push_back(mk(1, 14, 32'hE2,       0, 0, 0, 1, 0, 0, 0,  0,            0, 1, 0));
        vecs.push_back(mk(1, 3,  32'hE3,       0, 0, 0, 1, 0, 0, 0,  0,            0, 1, 1));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0, 1, 0, 0, 0,  0,            0, 1, 1));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_init");
        cmp("reset_init mu_gnt", 32'(bus.mu_gnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wv, vecs[i].wrd, vecs[i].wd, vecs[i].mreq, vecs[i].mrd,
                  vecs[i].md, vecs[i].bl);
            @(negedge clk);
            cmp("mu_gnt", 32'(bus.mu_gnt), 32'(vecs[i].egnt));
            sb.push_back('{vecs[i].eld, vecs[i].esel, vecs[i].eds, vecs[i].epc,
                           vecs[i].estall, vecs[i].eovf});
            @(posedge clk);
            #1;
            n_vec++;
            e = sb.pop_front();
            cmp("rf_ld", 32'(bus.rf_ld), 32'(e.eld));
            if (e.eld) begin
                cmp("rf_sel", 32'(bus.rf_sel), 32'(e.esel));
                cmp("rf_ds", bus.rf_ds, e.eds);
            end
            cmp("pc_ld", 32'(bus.pc_ld), 32'(e.epc));
            if (e.epc) cmp("pc_data", bus.pc_data, e.eds);
            cmp("wb_stall", 32'(bus.wb_stall), 32'(e.estall));
            cmp("overflow", 32'(bus.overflow), 32'(e.eovf));
        end

        // reset mid-stream with a live MU request: nothing granted, all cleared
        rst_n = 1'b0;
        drive(1'b1, 4'd6, 32'h66666666, 1'b1, 4'd6, 32'h60606060, 1'b0);
        @(negedge clk);
        cmp("reset_mid mu_gnt", 32'(bus.mu_gnt), 32'd0);
        @(posedge clk);
        #1;
        n_vec++;
        check_all_zero("reset_mid");

        // stale FIFO entries must never surface after release
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            cmp("post_reset rf_ld", 32'(bus.rf_ld), 32'd0);
            cmp("post_reset pc_ld", 32'(bus.pc_ld), 32'd0);
            cmp("post_reset wb_stall", 32'(bus.wb_stall), 32'd0);
            cmp("post_reset overflow", 32'(bus.overflow), 32'd0);
        end

        // arbiter still functional after reset
        drive(1'b1, 4'd3, 32'h33333333, 1'b0, 4'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        n_vec++;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
        cmp("post_reset wb rf_ld", 32'(bus.rf_ld), 32'd1);
        cmp("post_reset wb rf_sel", 32'(bus.rf_sel), 32'd3);
        cmp("post_reset wb rf_ds", bus.rf_ds, 32'h33333333);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
